// File: rtl/bit_packer_if.sv
//------------------------------------------------------------------------------
// Module      : bit_packer_if
// Description : Field-in / word-out handshake bundle for bit_packer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bit_packer_if #(
    parameter int WORD_W  = 64,
    parameter int FIELD_W = 32
);
    localparam int WIDTH_W = $clog2(FIELD_W) + 1;

    logic               in_valid;
    logic               in_ready;
    logic [FIELD_W-1:0] in_data;
    logic [WIDTH_W-1:0] in_width;
    logic               flush_req;
    logic               out_valid;
    logic               out_ready;
    logic [WORD_W-1:0]  out_data;
    logic               out_last;
    logic               flush_done;

    modport slave (
        input  in_valid, in_data, in_width, flush_req, out_ready,
        output in_ready, out_valid, out_data, out_last, flush_done
    );

    modport master (
        output in_valid, in_data, in_width, flush_req, out_ready,
        input  in_ready, out_valid, out_data, out_last, flush_done
    );
endinterface

`default_nettype wire

// File: rtl/bit_packer.sv
//------------------------------------------------------------------------------
// Module      : bit_packer
// Description : Packs variable-width fields LSB-first into WORD_W-bit words,
//               with a flush that drains a zero-padded final word.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bit_packer #(
    parameter int WORD_W  = 64,
    parameter int FIELD_W = 32
) (
    input  wire logic    clock,
    input  wire logic    rst_n,
    bit_packer_if.slave  bus
);
    localparam int BUF_W = WORD_W + FIELD_W;
    localparam int CNT_W = $clog2(BUF_W + 1);
    localparam logic [CNT_W-1:0] c_WORD_CNT = CNT_W'(WORD_W);

    typedef enum logic [0:0] {
        S_PACK  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t             r_state;
    logic [BUF_W-1:0]   r_buf;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_flush_done;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_in_fire;
    logic               w_out_fire;
    logic [BUF_W-1:0]   w_mask;
    logic [BUF_W-1:0]   w_field;
    logic [BUF_W-1:0]   w_buf_shift;
    logic [CNT_W-1:0]   w_cnt_add;

    assign w_in_ready  = (r_state == S_PACK) && (r_cnt < c_WORD_CNT);
    assign w_out_valid = (r_state == S_PACK) ? (r_cnt >= c_WORD_CNT)
                                             : (r_cnt != '0);
    assign w_in_fire   = w_in_ready && bus.in_valid;
    assign w_out_fire  = w_out_valid && bus.out_ready;

    // Mask and shift at full buffer width so a field straddling the word
    // boundary keeps its high bits in the upper part of the buffer.
    assign w_mask      = (BUF_W'(1) << bus.in_width) - BUF_W'(1);
    assign w_field     = (BUF_W'(bus.in_data) & w_mask) << r_cnt;
    assign w_buf_shift = r_buf >> WORD_W;
    assign w_cnt_add   = r_cnt + CNT_W'(bus.in_width);

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_state      <= S_PACK;
            r_buf        <= '0;
            r_cnt        <= '0;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;
            case (r_state)
                S_PACK: begin
                    // In and out never fire together here: in_ready needs
                    // cnt below a word, out_valid needs a full word.
                    if (w_out_fire) begin
                        r_buf <= w_buf_shift;
                        r_cnt <= r_cnt - c_WORD_CNT;
                    end else if (w_in_fire) begin
                        r_buf <= r_buf | w_field;
                        r_cnt <= w_cnt_add;
                    end
                    if (bus.flush_req) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (r_cnt == '0) begin
                        r_state      <= S_PACK;
                        r_flush_done <= 1'b1;
                    end else if (w_out_fire) begin
                        r_buf <= w_buf_shift;
                        r_cnt <= (r_cnt > c_WORD_CNT) ? (r_cnt - c_WORD_CNT) : '0;
                    end
                end
                default: begin
                    r_state <= S_PACK;
                end
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_data   = r_buf[WORD_W-1:0];
    assign bus.out_last   = (r_state == S_FLUSH) && (r_cnt <= c_WORD_CNT);
    assign bus.flush_done = r_flush_done;

endmodule

`default_nettype wire

// File: tb/tb_bit_packer.sv
//------------------------------------------------------------------------------
// Module      : tb_bit_packer
// Description : Scoreboard bench for bit_packer against a bit-queue model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_bit_packer;
    localparam int WORD_W  = 64;
    localparam int FIELD_W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bit_packer_if #(.WORD_W(WORD_W), .FIELD_W(FIELD_W)) bus ();

    bit_packer #(.WORD_W(WORD_W), .FIELD_W(FIELD_W)) dut (
        .clock (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          total  = 0;
    int          bad    = 0;
    int          n_xfer = 0;
    int          rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready
    bit          mq[$];          // pending stream bits, oldest first
    logic [63:0] exp_data[$];
    bit          exp_last[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout want completion", name);
    endtask

    // Reference model: a plain bit queue chopped into words
    task automatic model_push(input logic [31:0] d, input int w);
        for (int i = 0; i < w; i++) mq.push_back(d[i]);
    endtask

    task automatic model_emit(input bit last);
        logic [63:0] word;
        word = '0;
        for (int i = 0; i < WORD_W; i++)
            if (mq.size() != 0) word[i] = mq.pop_front();
        exp_data.push_back(word);
        exp_last.push_back(last);
    endtask

    task automatic model_flush();
        while (mq.size() != 0) model_emit(mq.size() <= WORD_W);
    endtask

    // out_ready driver
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = ($urandom_range(0, 3) != 0);
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [63:0] prev_data;
        bit          prev_last;
        bit          prev_hold;
        prev_hold = 0;
        prev_data = '0;
        prev_last = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 0;
            end else begin
                if (bus.out_valid) check("ready_excl", 64'(bus.in_ready), 64'(0));
                if (prev_hold) begin
                    check("hold_valid", 64'(bus.out_valid), 64'(1));
                    check("hold_data", bus.out_data, prev_data);
                    check("hold_last", 64'(bus.out_last), 64'(prev_last));
                end
                if (bus.out_valid && bus.out_ready) begin
                    n_xfer++;
                    if (exp_data.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_word: got %h want none", bus.out_data);
                    end else begin
                        check("word_data", bus.out_data, exp_data.pop_front());
                        check("word_last", 64'(bus.out_last), 64'(exp_last.pop_front()));
                    end
                end
                prev_hold = bus.out_valid && !bus.out_ready;
                prev_data = bus.out_data;
                prev_last = bus.out_last;
            end
        end
    end

    task automatic send_field(input logic [31:0] d, input int w);
        int guard;
        bit r;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_width = 6'(w);
        guard = 0;
        r = 0;
        forever begin
            @(negedge clk);
            r = bus.in_ready;
            @(posedge clk);
            if (r) break;
            guard++;
            if (guard > 300) break;
        end
        #1;
        bus.in_valid = 1'b0;
        bus.in_width = '0;
        if (r) begin
            model_push(d, w);
            while (mq.size() >= WORD_W) model_emit(0);
        end else begin
            note_fail("send_field");
        end
    endtask

    task automatic wait_drained();
        int guard;
        guard = 0;
        while (exp_data.size() != 0 && guard < 400) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (exp_data.size() != 0) note_fail("drain");
    endtask

    task automatic flush_issue(input bit with_f, input logic [31:0] d, input int w);
        wait_drained();
        bus.flush_req = 1'b1;
        if (with_f) begin
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            bus.in_width = 6'(w);
        end
        @(posedge clk);
        #1;
        bus.flush_req = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_width  = '0;
        if (with_f) model_push(d, w);
        model_flush();
    endtask

    task automatic flush_wait();
        int guard;
        guard = 0;
        forever begin
            @(negedge clk);
            if (bus.flush_done) break;
            guard++;
            if (guard > 400) break;
        end
        if (!bus.flush_done) begin
            note_fail("flush_done_wait");
        end else begin
            check("flush_words_done", 64'(exp_data.size()), 64'(0));
            @(negedge clk);
            check("flush_done_pulse", 64'(bus.flush_done), 64'(0));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          lowc;
        int          n0;
        logic [63:0] hd;
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lowc;
        int          n0;
        logic [63:0] hd;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_width  = '0;
        bus.flush_req = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_last", 64'(bus.out_last), 64'(0));
        check("rst_out_data", bus.out_data, 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("rst_flush_done", 64'(bus.flush_done), 64'(0));
        rst_n = 1'b1;
        rdy_mode = 1;
        @(posedge clk);
        #1;

        // eight bytes -> one word, one-cycle in_ready gap
        for (int i = 0; i < 8; i++) send_field(32'(8'h11 * (i + 1)), 8);
        lowc = 0;
        repeat (4) begin
            @(negedge clk);
            if (!bus.in_ready) lowc++;
        end
        check("pack8_ready_gap", 64'(lowc), 64'(1));
        @(posedge clk);
        #1;
        wait_drained();

        // 3-bit field then flush
        send_field(32'hFF, 3);
        flush_issue(0, '0, 0);
        flush_wait();

        // straddling field
        send_field(32'h3FFF_FFFF, 30);
        send_field(32'h3FFF_FFFF, 30);
        send_field(32'hAB, 8);
        wait_drained();
        flush_issue(0, '0, 0);
        flush_wait();

        // backpressure hold
        rdy_mode = 2;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) send_field($urandom, 8);
        @(negedge clk);
        hd = bus.out_data;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", 64'(bus.out_valid), 64'(1));
            check("bp_in_ready", 64'(bus.in_ready), 64'(0));
            check("bp_data", bus.out_data, hd);
        end
        n0 = n_xfer;
        rdy_mode = 1;
        repeat (4) @(negedge clk);
        check("bp_one_xfer", 64'(n_xfer - n0), 64'(1));
        @(posedge clk);
        #1;
        wait_drained();

        // empty flush, zero-width fields, flush_req held into FLUSH
        send_field($urandom, 0);
        send_field($urandom, 0);
        bus.flush_req = 1'b1;
        @(posedge clk);
        #1;
        check("eflush_done_early", 64'(bus.flush_done), 64'(0));
        @(posedge clk);
        #1;
        bus.flush_req = 1'b0;
        check("eflush_done", 64'(bus.flush_done), 64'(1));
        check("eflush_no_valid", 64'(bus.out_valid), 64'(0));
        @(posedge clk);
        #1;
        check("eflush_done_pulse", 64'(bus.flush_done), 64'(0));

        // reset in the middle of a flush
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send_field($urandom, 32);
        send_field($urandom, 8);
        flush_issue(0, '0, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        mq.delete();
        exp_data.delete();
        exp_last.delete();
        @(posedge clk);
        #1;
        check("mrst_out_valid", 64'(bus.out_valid), 64'(0));
        check("mrst_in_ready", 64'(bus.in_ready), 64'(1));
        check("mrst_flush_done", 64'(bus.flush_done), 64'(0));
        check("mrst_out_data", bus.out_data, 64'(0));
        rst_n = 1'b1;
        rdy_mode = 1;
        send_field($urandom, 32);
        send_field($urandom, 32);
        wait_drained();

        // randomized traffic with periodic flushes
        rdy_mode = 0;
        for (int k = 0; k < 400; k++) begin
            if (k % 37 == 36) begin
                flush_issue(1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 32)));
                flush_wait();
            end else begin
                send_field($urandom, int'($urandom_range(0, 32)));
            end
        end
        flush_issue(0, '0, 0);
        flush_wait();
        wait_drained();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
